// File: rtl/top_pkg.sv
// Hamming SEC / SECDED helpers shared by the error-corrected counter.
// Functions work on maximum-size vectors and take the data width as an argument.
package top_pkg;

  localparam int MAX_W = 57;
  localparam int MAX_R = 6;
  localparam int MAX_N = MAX_W + MAX_R;

  typedef logic [MAX_W-1:0] data_t;
  typedef logic [MAX_R-1:0] check_t;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_SINGLE = 2'd1,
    ERR_DOUBLE = 2'd2
  } err_kind_e;

  // Smallest r with 2^r >= w + r + 1; the descending scan leaves the smallest hit.
  function automatic int calc_r(input int w);
    int r;
    r = MAX_R;
    for (int k = MAX_R; k >= 1; k--) begin
      if ((1 << k) >= w + k + 1) r = k;
    end
    return r;
  endfunction

  function automatic bit is_pow2(input int p);
    return (p > 0) && ((p & (p - 1)) == 0);
  endfunction

  // Codeword position (non power of two) -> data bit index, LSB first.
  function automatic int pos_to_data_idx(input int p);
    int below;
    below = 0;
    for (int j = 0; j <= MAX_R; j++) begin
      if ((1 << j) <= p) below++;
    end
    return p - below - 1;
  endfunction

  // Even-parity Hamming check bits: XOR of the positions of every set data bit.
  function automatic check_t encode(input data_t data, input int w);
    check_t c;
    data_t  sh;
    int     n;
    c = '0;
    n = w + calc_r(w);
    for (int p = 3; p <= MAX_N; p++) begin
      if (p <= n && !is_pow2(p)) begin
        sh = data >> pos_to_data_idx(p);
        if (sh[0]) c ^= check_t'(p);
      end
    end
    return c;
  endfunction

  function automatic check_t syndrome(input data_t data, input check_t check, input int w);
    return check ^ encode(data, w);
  endfunction

endpackage

// File: rtl/top_counter_and_parity.sv
// Counter register with stored Hamming check bits, corrector and incrementer.
// SECDED_EN adds an overall-parity bit and double-error detection.
module counter_and_parity
  import top_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic [WIDTH-1:0] counter,
  output logic             err_corrected,
  output logic             err_double
);

  localparam int R = calc_r(WIDTH);
  localparam int N = WIDTH + R;
`ifdef SECDED_EN
  localparam int PW = R + 1;
`else
  localparam int PW = R;
`endif

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] corrected;
  logic [WIDTH-1:0] flip_mask;
  logic [PW-1:0]    parity_stored;
  logic [PW-1:0]    parity_d;
  check_t           syn;
  check_t           enc_next;
  logic [R-1:0]     enc_r;
  logic             single_err;
  logic             double_err;
  err_kind_e        err_kind;

  assign syn = syndrome(data_t'(count_reg), check_t'(parity_stored[R-1:0]), WIDTH);

  // One decoder term per data position; check positions never flip data.
  for (genvar gi = 1; gi <= N; gi++) begin : g_pos
    if (!is_pow2(gi)) begin : g_data
      assign flip_mask[pos_to_data_idx(gi)] = (syn == check_t'(gi));
    end
  end

  always_comb begin
    single_err = 1'b0;
    double_err = 1'b0;
`ifdef SECDED_EN
    if (^{count_reg, parity_stored}) begin
      single_err = 1'b1;
    end else if (syn != '0) begin
      double_err = 1'b1;
    end
`else
    single_err = (syn != '0);
`endif
    err_kind = ERR_NONE;
    if (double_err) begin
      err_kind = ERR_DOUBLE;
    end else if (single_err) begin
      err_kind = ERR_SINGLE;
    end
  end

  assign corrected = (err_kind == ERR_SINGLE) ? (count_reg ^ flip_mask) : count_reg;

  // A double error freezes the raw value but still re-encodes it.
  assign count_d  = corrected + WIDTH'((err_kind != ERR_DOUBLE) && enable);
  assign enc_next = encode(data_t'(count_d), WIDTH);
  assign enc_r    = R'(enc_next);

`ifdef SECDED_EN
  assign parity_d = {^{count_d, enc_r}, enc_r};
`else
  assign parity_d = enc_r;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg     <= '0;
      parity_stored <= '0;
    end else begin
      count_reg     <= count_d;
      parity_stored <= parity_d;
    end
  end

  assign counter       = corrected;
  assign err_corrected = (err_kind == ERR_SINGLE);
  assign err_double    = (err_kind == ERR_DOUBLE);

endmodule

// File: rtl/top.sv
// Self-scrubbing Hamming-protected counter; SECDED_EN enables double-error detection.
// Wrapper only: all state lives in counter_and_parity.
module top #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic [WIDTH-1:0] counter,
  output logic             err_corrected,
  output logic             err_double
);

  counter_and_parity #(
    .WIDTH(WIDTH)
  ) counter_and_parity (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .counter      (counter),
    .err_corrected(err_corrected),
    .err_double   (err_double)
  );

endmodule

// File: tb/tb_top.sv
// Bench for top: codeword-level error model with random upsets plus directed cases.
// Works in both builds (SECDED_EN defined or not).
module tb_top;

  localparam int W = 16;
  localparam int R = 5;
  localparam int N = W + R;
`ifdef SECDED_EN
  localparam int PW = R + 1;
  localparam bit SECDED = 1'b1;
`else
  localparam int PW = R;
  localparam bit SECDED = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         enable = 1'b0;
  logic [W-1:0] counter;
  logic         err_corrected;
  logic         err_double;

  top #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .counter      (counter),
    .err_corrected(err_corrected),
    .err_double   (err_double)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [W-1:0]  mval = '0;     // value the stored word is meant to hold
  logic [W-1:0]  exp_cnt = '0;
  logic          exp_corr = 1'b0;
  logic          exp_dbl = 1'b0;
  bit            chk_en = 1'b0;
  logic [W-1:0]  obs_cnt;
  logic          obs_corr;
  logic          obs_dbl;
  logic [W-1:0]  inj_d;
  logic [PW-1:0] inj_p;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_counter", counter, exp_cnt);
      check("cyc_err_corrected", err_corrected, exp_corr);
      check("cyc_err_double", err_double, exp_dbl);
    end
  end

  function automatic bit is_p2(input int p);
    return (p > 0) && ((p & (p - 1)) == 0);
  endfunction

  // Data index -> codeword position.
  function automatic int dpos(input int i);
    int cnt;
    cnt = -1;
    for (int p = 1; p <= N; p++) begin
      if (!is_p2(p)) begin
        cnt++;
        if (cnt == i) return p;
      end
    end
    return 0;
  endfunction

  function automatic int didx(input int p);
    for (int i = 0; i < W; i++) begin
      if (dpos(i) == p) return i;
    end
    return 0;
  endfunction

  function automatic logic [PW-1:0] henc(input logic [W-1:0] v);
    logic [R-1:0] c;
    c = '0;
    for (int i = 0; i < W; i++) begin
      if (v[i]) c ^= R'(dpos(i));
    end
`ifdef SECDED_EN
    return {^v ^ ^c, c};
`else
    return c;
`endif
  endfunction

  // Called at posedge+1; upsets codeword positions (0 = overall bit) and advances one edge.
  task automatic step(input bit en, input int np, input int p0, input int p1);
    logic [W-1:0]  dmask;
    logic [W-1:0]  raw;
    logic [PW-1:0] pmask;
    int            syn;
    int            pos[2];
    bit            corr;
    bit            dbl;
    dmask = '0;
    pmask = '0;
    syn   = 0;
    corr  = 1'b0;
    dbl   = 1'b0;
    pos[0] = p0;
    pos[1] = p1;
    for (int k = 0; k < np; k++) begin
      if (pos[k] == 0) begin
        pmask ^= PW'(1) << (PW - 1);
      end else if (is_p2(pos[k])) begin
        for (int j = 0; j < R; j++) begin
          if (pos[k] == (1 << j)) pmask ^= PW'(1) << j;
        end
      end else begin
        dmask ^= W'(1) << didx(pos[k]);
      end
      syn ^= pos[k];
    end
    raw = mval ^ dmask;
    enable = en;
    if (np > 0) begin
      inj_d = raw;
      inj_p = henc(mval) ^ pmask;
      force dut.counter_and_parity.count_reg = inj_d;
      force dut.counter_and_parity.parity_stored = inj_p;
      #1;
      release dut.counter_and_parity.count_reg;
      release dut.counter_and_parity.parity_stored;
    end
    if (SECDED) begin
      if ((np % 2) == 1) corr = 1'b1;
      else if (syn != 0) dbl = 1'b1;
    end else begin
      corr = (syn != 0);
    end
    exp_cnt = raw;
    if (corr && syn != 0 && syn <= N && !is_p2(syn)) exp_cnt = raw ^ (W'(1) << didx(syn));
    exp_corr = corr;
    exp_dbl  = dbl;
    #2;
    obs_cnt  = counter;
    obs_corr = err_corrected;
    obs_dbl  = err_double;
    @(posedge clk);
    #1;
    mval = exp_cnt + (dbl ? W'(0) : W'(en));
    $display("step en=%0d flips=%0d p0=%0d p1=%0d out=%h corr=%0d dbl=%0d next=%h",
             en, np, p0, p1, exp_cnt, corr, dbl, mval);
  endtask

  initial begin
    #2;
    check("rst_counter", counter, 0);
    check("rst_err_corrected", err_corrected, 0);
    check("rst_err_double", err_double, 0);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    repeat (10) step(1'b1, 0, 0, 0);
    check("count_to_10", counter, 16'h000A);

    step(1'b0, 1, dpos(5), 0);
    check("upset_counter_during", obs_cnt, 16'h000A);
    check("upset_corr_during", obs_corr, 1);
    check("upset_counter_after", counter, 16'h000A);
    check("upset_corr_after", err_corrected, 0);
    check("upset_scrubbed_reg", dut.counter_and_parity.count_reg, 16'h000A);

    repeat (5) step(1'b1, 0, 0, 0);
    check("resume_to_15", counter, 16'h000F);

    step(1'b0, 1, 1, 0);
    check("chk_upset_counter", obs_cnt, 16'h000F);
    check("chk_upset_corr", obs_corr, 1);
    check("chk_upset_corr_after", err_corrected, 0);
`ifdef SECDED_EN
    check("chk_parity_restored", dut.counter_and_parity.parity_stored, 6'h27);
`else
    check("chk_parity_restored", dut.counter_and_parity.parity_stored, 5'h07);
`endif

    inj_d = 16'hFFFF;
    inj_p = henc(16'hFFFF);
    force dut.counter_and_parity.count_reg = inj_d;
    force dut.counter_and_parity.parity_stored = inj_p;
    #1;
    release dut.counter_and_parity.count_reg;
    release dut.counter_and_parity.parity_stored;
    mval = 16'hFFFF;
    step(1'b1, 0, 0, 0);
    check("wrap_before_flag", obs_corr, 0);
    check("wrap_counter", counter, 16'h0000);
    check("wrap_err_corrected", err_corrected, 0);
    check("wrap_err_double", err_double, 0);

    step(1'b1, 2, dpos(0), dpos(1));
`ifdef SECDED_EN
    check("dbl_flag", obs_dbl, 1);
    check("dbl_corr", obs_corr, 0);
    check("dbl_raw_counter", obs_cnt, 16'h0003);
    check("dbl_hold", counter, 16'h0003);
`else
    check("dbl_flag_tied0", obs_dbl, 0);
    check("dbl_miscorrect", obs_cnt, 16'h0007);
    check("dbl_after", counter, 16'h0008);
`endif

    for (int t = 0; t < 300; t++) begin
      int r;
      int np;
      int p0;
      int p1;
      int lo;
      lo = SECDED ? 0 : 1;
      r  = $urandom_range(99, 0);
      np = (r < 15) ? 1 : ((r < 22) ? 2 : 0);
      p0 = $urandom_range(N, lo);
      p1 = p0;
      while (p1 == p0) p1 = $urandom_range(N, lo);
      step($urandom_range(3, 0) != 0, np, p0, p1);
    end

    repeat (3) step(1'b1, 0, 0, 0);
    #2;
    exp_cnt  = '0;
    exp_corr = 1'b0;
    exp_dbl  = 1'b0;
    mval     = '0;
    rst = 1'b0;
    #1;
    check("midrst_counter", counter, 0);
    check("midrst_err_corrected", err_corrected, 0);
    check("midrst_err_double", err_double, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1'b1, 0, 0, 0);
    check("after_rst_first", counter, 16'h0001);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
